regfile_wb_arbiter: RTL and testbench

Owns the single write port (we/addrw/dataw) of the register file and shares it between two writeback requesters using valid/ready handshakes with round-robin priority.
The register file has no reset, so after reset (and on demand) the block first walks every register and writes zero before granting any requester.
It sits between the execute/load writeback paths and the regfile write port.

---
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port owner: zero-clears every register after reset or on clr_req,
// then arbitrates two writeback requesters round-robin onto a registered write port.
module regfile_wb_arbiter #(
  parameter  int N    = 16,
  parameter  int XLEN = 32,
  localparam int RA   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  input  logic            req0_valid,
  input  logic [RA-1:0]   req0_addr,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [RA-1:0]   req1_addr,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic            we,
  output logic [RA-1:0]   addrw,
  output logic [XLEN-1:0] dataw,
  output logic            init_done
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [RA-1:0] LAST_ADDR = RA'(N - 1);

  state_t          state_q;
  logic [RA-1:0]   cnt_q;
  logic            prio_q;
  logic            we_q;
  logic [RA-1:0]   addrw_q;
  logic [XLEN-1:0] dataw_q;
  logic            grant_ok;

  // A clear request blocks acceptance in the same cycle it is seen.
  assign grant_ok = (state_q == RUN) && !clr_req;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (grant_ok) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      addrw_q <= '0;
      dataw_q <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          we_q    <= 1'b1;
          addrw_q <= cnt_q;
          dataw_q <= '0;
          if (cnt_q == LAST_ADDR) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            we_q    <= 1'b0;
          end else if (req0_ready) begin
            we_q    <= 1'b1;
            addrw_q <= req0_addr;
            dataw_q <= req0_data;
            prio_q  <= 1'b1;
          end else if (req1_ready) begin
            we_q    <= 1'b1;
            addrw_q <= req1_addr;
            dataw_q <= req1_data;
            prio_q  <= 1'b0;
          end else begin
            we_q <= 1'b0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign we        = we_q;
  assign addrw     = addrw_q;
  assign dataw     = dataw_q;
  assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// handshake traffic, checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N    = 16;
  localparam int XLEN = 32;
  localparam int RA   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr_req = 1'b0;
  logic            req0_valid = 1'b0;
  logic [RA-1:0]   req0_addr = '0;
  logic [XLEN-1:0] req0_data = '0;
  logic            req0_ready;
  logic            req1_valid = 1'b0;
  logic [RA-1:0]   req1_addr = '0;
  logic [XLEN-1:0] req1_data = '0;
  logic            req1_ready;
  logic            we;
  logic [RA-1:0]   addrw;
  logic [XLEN-1:0] dataw;
  logic            init_done;

  regfile_wb_arbiter #(.N(N), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .we         (we),
    .addrw      (addrw),
    .dataw      (dataw),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures   = 0;

  // Behavioural model: "clear writes still owed", round-robin pointer, expected port.
  bit              m_init;
  int              m_clear_idx;
  int              m_prio;
  logic            m_we;
  logic [RA-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  int              last_winner;

  function automatic void model_reset();
    m_init      = 1'b0;
    m_clear_idx = 0;
    m_prio      = 0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_data      = '0;
    last_winner = -1;
  endfunction

  function automatic int pick_winner();
    if (!m_init || clr_req) return -1;
    if (req0_valid && req1_valid) return m_prio;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic void model_advance(input int w);
    if (!m_init) begin
      m_we   = 1'b1;
      m_addr = RA'(m_clear_idx);
      m_data = '0;
      m_clear_idx++;
      if (m_clear_idx == N) begin
        m_init      = 1'b1;
        m_clear_idx = 0;
      end
    end else if (clr_req) begin
      m_init      = 1'b0;
      m_clear_idx = 0;
      m_we        = 1'b0;
    end else if (w == 0) begin
      m_we   = 1'b1;
      m_addr = req0_addr;
      m_data = req0_data;
      m_prio = 1;
    end else if (w == 1) begin
      m_we   = 1'b1;
      m_addr = req1_addr;
      m_data = req1_data;
      m_prio = 0;
    end else begin
      m_we = 1'b0;
    end
    last_winner = w;
  endfunction

  // One clock: compare everything at the falling edge, advance the model at the rising edge.
  task automatic step();
    int   w;
    logic e0, e1;
    @(negedge clk);
    w  = pick_winner();
    e0 = (w == 0);
    e1 = (w == 1);
    assertions++;
    if (req0_ready !== e0) begin
      failures++;
      $display("FAIL req0_ready: got %b expected %b at %0t", req0_ready, e0, $time);
    end
    assertions++;
    if (req1_ready !== e1) begin
      failures++;
      $display("FAIL req1_ready: got %b expected %b at %0t", req1_ready, e1, $time);
    end
    assertions++;
    if (we !== m_we) begin
      failures++;
      $display("FAIL we: got %b expected %b at %0t", we, m_we, $time);
    end
    assertions++;
    if (addrw !== m_addr) begin
      failures++;
      $display("FAIL addrw: got %0d expected %0d at %0t", addrw, m_addr, $time);
    end
    assertions++;
    if (dataw !== m_data) begin
      failures++;
      $display("FAIL dataw: got %h expected %h at %0t", dataw, m_data, $time);
    end
    assertions++;
    if (init_done !== m_init) begin
      failures++;
      $display("FAIL init_done: got %b expected %b at %0t", init_done, m_init, $time);
    end
    @(posedge clk);
    model_advance(w);
    #1;
  endtask

  task automatic check_clear_walk(input string tag);
    for (int i = 0; i < N; i++) begin
      step();
      assertions++;
      if (we !== 1'b1 || addrw !== RA'(i) || dataw !== '0) begin
        failures++;
        $display("FAIL %s clear write %0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=0",
                 tag, i, we, addrw, dataw, i);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #3;
    assertions++;
    if ({we, addrw, dataw, init_done, req0_ready, req1_ready} !== '0) begin
      failures++;
      $display("FAIL reset_state: got we=%b addr=%0d data=%h init=%b r0=%b r1=%b expected all 0",
               we, addrw, dataw, init_done, req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_clear_walk("reset");
    step();
    assertions++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_after_clear: got %b expected 1", init_done);
    end
  endtask

  task automatic test_alternate();
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'h1111;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      step();
      assertions++;
      if (we !== 1'b1 || addrw !== ((i % 2) ? 4'd2 : 4'd1)) begin
        failures++;
        $display("FAIL alternate grant %0d: got we=%b addr=%0d expected we=1 addr=%0d",
                 i, we, addrw, (i % 2) ? 2 : 1);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 32'h0101;
    step();
    req0_valid = 1'b0;
    assertions++;
    if (we !== 1'b1 || addrw !== 4'd3 || dataw !== 32'h0101) begin
      failures++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h expected we=1 addr=3 data=00000101",
               we, addrw, dataw);
    end
    step();
    assertions++;
    if (we !== 1'b0 || addrw !== 4'd3) begin
      failures++;
      $display("FAIL single_idle: got we=%b addr=%0d expected we=0 addr=3", we, addrw);
    end
  endtask

  task automatic test_req1_streak();
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_addr = RA'(8 + i);
      req1_data = $urandom;
      step();
      assertions++;
      if (we !== 1'b1 || addrw !== RA'(8 + i) || dataw !== req1_data) begin
        failures++;
        $display("FAIL req1_streak %0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                 i, we, addrw, dataw, 8 + i, req1_data);
      end
    end
    req1_addr = 4'd12; req1_data = 32'hAAAA_0001;
    req0_valid = 1'b1; req0_addr = 4'd13; req0_data = 32'hBBBB_0002;
    step();
    assertions++;
    if (addrw !== 4'd13 || dataw !== 32'hBBBB_0002) begin
      failures++;
      $display("FAIL contended_after_streak: got addr=%0d data=%h expected addr=13 data=bbbb0002",
               addrw, dataw);
    end
    req0_valid = 1'b0;
    step();
    assertions++;
    if (addrw !== 4'd12 || dataw !== 32'hAAAA_0001) begin
      failures++;
      $display("FAIL req1_after_contend: got addr=%0d data=%h expected addr=12 data=aaaa0001",
               addrw, dataw);
    end
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_clr_req();
    logic [XLEN-1:0] d;
    d = $urandom;
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = d;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    assertions++;
    if (we !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL clr_req_edge: got we=%b init=%b expected we=0 init=0", we, init_done);
    end
    check_clear_walk("clr_req");
    step();
    assertions++;
    if (we !== 1'b1 || addrw !== 4'd5 || dataw !== d) begin
      failures++;
      $display("FAIL post_clear_accept: got we=%b addr=%0d data=%h expected we=1 addr=5 data=%h",
               we, addrw, dataw, d);
    end
    req0_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (8) step();
    assertions++;
    if (we !== 1'b1 || addrw !== 4'd7) begin
      failures++;
      $display("FAIL pre_reset_addr: got we=%b addr=%0d expected we=1 addr=7", we, addrw);
    end
    #2;
    rst_n = 1'b0;
    #1;
    assertions++;
    if (we !== 1'b0 || addrw !== '0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got we=%b addr=%0d init=%b expected we=0 addr=0 init=0",
               we, addrw, init_done);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_clear_walk("restart");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid && ($urandom_range(2) == 0)) begin
        req0_valid = 1'b1;
        req0_addr  = RA'($urandom_range(N - 1));
        req0_data  = $urandom;
      end
      if (!req1_valid && ($urandom_range(2) == 0)) begin
        req1_valid = 1'b1;
        req1_addr  = RA'($urandom_range(N - 1));
        req1_data  = $urandom;
      end
      clr_req = !clr_req && ($urandom_range(59) == 0);
      step();
      if (last_winner == 0) req0_valid = 1'b0;
      if (last_winner == 1) req1_valid = 1'b0;
    end
    clr_req    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_req1_streak();
    test_clr_req();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
